// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the debug-side instruction memory loader.
// Imported by the loader top and its word assembler.
package inst_mem_loader_pkg;

  typedef enum logic [2:0] {
    LOAD,
    WRITE,
    WAIT_CMD,
    RUN,
    STEP,
    DONE
  } state_t;

  localparam logic [7:0]  CMD_CONT_DEF  = 8'h43;
  localparam logic [7:0]  CMD_STEP_DEF  = 8'h53;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/inst_mem_loader_word_assembler.sv
// Packs UART bytes big-endian into 32-bit words.
// word_done flags the capture that completes a word.
module inst_mem_loader_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic [7:0]  rx_byte,
  output logic [31:0] word_next,
  output logic        word_done
);

  logic [1:0]  cnt;
  logic [23:0] shift;

  assign word_next = {shift, rx_byte};
  assign word_done = capture && (cnt == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= 2'd0;
      shift <= 24'd0;
    end else if (capture) begin
      cnt   <= cnt + 2'd1;
      shift <= {shift[15:0], rx_byte};
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Loads instruction memory from UART bytes, then gates the
// pipeline (run or single-step) until the program halts.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int          MEM_DEPTH = 256,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF,
  parameter logic [7:0]  CMD_CONT  = CMD_CONT_DEF,
  parameter logic [7:0]  CMD_STEP  = CMD_STEP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_rx_data,
  input  logic        in_rx_done,
  input  logic        in_halt_flag,
  output logic        out_debug_flag,
  output logic [31:0] out_addr_debug,
  output logic [31:0] out_ins_to_mem,
  output logic        out_wea_ram_inst,
  output logic        out_pipe_enable,
  output logic        out_load_done,
  output logic        out_load_error
);

  localparam logic [31:0] LAST_ADDR =
    32'(4 * (MEM_DEPTH - 1));

  state_t      state;
  logic        is_halt;
  logic        at_last;
  logic        leaving;
  logic        capture;
  logic [31:0] word_next;
  logic        word_done;

  assign is_halt = (out_ins_to_mem == HALT_WORD);
  assign at_last = (out_addr_debug == LAST_ADDR);
  assign leaving = is_halt || at_last;

  // A byte landing in WRITE starts the next word unless loading ends.
  assign capture = in_rx_done &&
    ((state == LOAD) || ((state == WRITE) && !leaving));

  inst_mem_loader_word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .capture   (capture),
    .rx_byte   (in_rx_data),
    .word_next (word_next),
    .word_done (word_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= LOAD;
      out_debug_flag   <= 1'b1;
      out_addr_debug   <= 32'd0;
      out_ins_to_mem   <= 32'd0;
      out_wea_ram_inst <= 1'b0;
      out_pipe_enable  <= 1'b0;
      out_load_done    <= 1'b0;
      out_load_error   <= 1'b0;
    end else begin
      out_wea_ram_inst <= 1'b0;
      unique case (state)
        LOAD: begin
          if (word_done) begin
            state            <= WRITE;
            out_wea_ram_inst <= 1'b1;
            out_ins_to_mem   <= word_next;
          end
        end
        WRITE: begin
          if (is_halt) begin
            state          <= WAIT_CMD;
            out_debug_flag <= 1'b0;
            out_load_done  <= 1'b1;
          end else if (at_last) begin
            state          <= WAIT_CMD;
            out_debug_flag <= 1'b0;
            out_load_done  <= 1'b1;
            out_load_error <= 1'b1;
          end else begin
            state          <= LOAD;
            out_addr_debug <= out_addr_debug + 32'd4;
          end
        end
        WAIT_CMD: begin
          if (in_rx_done) begin
            if (in_rx_data == CMD_CONT) begin
              state           <= RUN;
              out_pipe_enable <= 1'b1;
            end else if (in_rx_data == CMD_STEP) begin
              state           <= STEP;
              out_pipe_enable <= 1'b1;
            end
          end
        end
        RUN: begin
          if (in_halt_flag) begin
            state           <= DONE;
            out_pipe_enable <= 1'b0;
          end
        end
        STEP: begin
          out_pipe_enable <= 1'b0;
          state <= in_halt_flag ? DONE : WAIT_CMD;
        end
        DONE: begin
          out_pipe_enable <= 1'b0;
        end
        default: begin
          state           <= DONE;
          out_pipe_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: directed table, corner sequences
// and randomized loads against a word-list reference model.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, sel;
  logic        rx_done, halt;
  logic [7:0]  rx_data;

  logic        dbg_a, wea_a, pipe_a, done_a, err_a;
  logic [31:0] addr_a, ins_a;
  logic        dbg_b, wea_b, pipe_b, done_b, err_b;
  logic [31:0] addr_b, ins_b;

  int n_cmp = 0;
  int n_bad = 0;
  int pipe_cnt_a = 0;
  int pipe_cnt_b = 0;
  logic [63:0] wq_a[$];
  logic [63:0] wq_b[$];

  always #5 clk = ~clk;

  inst_mem_loader u_a (
    .clk              (clk),
    .reset            (rst_a),
    .in_rx_data       (rx_data),
    .in_rx_done       (rx_done & ~sel),
    .in_halt_flag     (halt),
    .out_debug_flag   (dbg_a),
    .out_addr_debug   (addr_a),
    .out_ins_to_mem   (ins_a),
    .out_wea_ram_inst (wea_a),
    .out_pipe_enable  (pipe_a),
    .out_load_done    (done_a),
    .out_load_error   (err_a)
  );

  inst_mem_loader #(.MEM_DEPTH(4)) u_b (
    .clk              (clk),
    .reset            (rst_b),
    .in_rx_data       (rx_data),
    .in_rx_done       (rx_done & sel),
    .in_halt_flag     (halt),
    .out_debug_flag   (dbg_b),
    .out_addr_debug   (addr_b),
    .out_ins_to_mem   (ins_b),
    .out_wea_ram_inst (wea_b),
    .out_pipe_enable  (pipe_b),
    .out_load_done    (done_b),
    .out_load_error   (err_b)
  );

  always @(negedge clk) begin
    if (wea_a) wq_a.push_back({addr_a, ins_a});
    if (wea_b) wq_b.push_back({addr_b, ins_b});
    if (pipe_a) pipe_cnt_a <= pipe_cnt_a + 1;
    if (pipe_b) pipe_cnt_b <= pipe_cnt_b + 1;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_done = 1'b1;
    cyc();
    rx_done = 1'b0;
    repeat (gap) cyc();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send(w[31-8*i -: 8], gap);
  endtask

  typedef struct {
    logic [31:0] word;
    logic [31:0] exp_addr;
    logic        exp_done;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int p0;
    logic [31:0] w;
    logic [63:0] exp_q[$];
    logic [63:0] act_e;
    logic [63:0] exp_e;
    int n;

    vecs[0] = '{32'hAC03_0000, 32'd0, 1'b0};
    vecs[1] = '{32'hAC03_3333, 32'd4, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'd8, 1'b1};

    rst_a = 1'b0; rst_b = 1'b0; sel = 1'b0;
    rx_done = 1'b0; halt = 1'b0; rx_data = 8'h00;
    repeat (2) cyc();
    chk("rst_debug", 32'(dbg_a), 32'd1);
    chk("rst_addr", addr_a, 32'd0);
    chk("rst_word", ins_a, 32'd0);
    chk("rst_wea", 32'(wea_a), 32'd0);
    chk("rst_pipe", 32'(pipe_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    rst_a = 1'b1; rst_b = 1'b1;
    cyc();

    // tests 1-2: table of words
    for (int i = 0; i < 3; i++) begin
      wq_a.delete();
      send_word(vecs[i].word, 0);
      repeat (2) cyc();
      chk("tbl_nwrites", 32'(wq_a.size()), 32'd1);
      if (wq_a.size() > 0) begin
        chk("tbl_addr", wq_a[0][63:32], vecs[i].exp_addr);
        chk("tbl_word", wq_a[0][31:0], vecs[i].word);
      end
      chk("tbl_done", 32'(done_a), 32'(vecs[i].exp_done));
      chk("tbl_debug", 32'(dbg_a), 32'(!vecs[i].exp_done));
      chk("tbl_pipe", 32'(pipe_a), 32'd0);
    end
    chk("t2_err", 32'(err_a), 32'd0);

    // test 3: halt outside RUN is ignored, then two steps
    halt = 1'b1;
    repeat (2) cyc();
    halt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      p0 = pipe_cnt_a;
      send(8'h53, 4);
      chk("step_pulse", 32'(pipe_cnt_a - p0), 32'd1);
      chk("step_debug", 32'(dbg_a), 32'd0);
    end
    p0 = pipe_cnt_a;
    send(8'h41, 3);
    chk("other_cmd", 32'(pipe_cnt_a - p0), 32'd0);

    // test 4: run, halt 10 cycles later together with a byte
    p0 = pipe_cnt_a;
    send(8'h43, 0);
    repeat (9) cyc();
    halt = 1'b1;
    rx_data = 8'h53;
    rx_done = 1'b1;
    cyc();
    halt = 1'b0;
    rx_done = 1'b0;
    cyc();
    chk("run_len", 32'(pipe_cnt_a - p0), 32'd10);
    chk("run_pipe_off", 32'(pipe_a), 32'd0);
    p0 = pipe_cnt_a;
    send(8'h43, 2);
    send(8'h53, 2);
    chk("done_ignore", 32'(pipe_cnt_a - p0), 32'd0);

    // test 5: overflow on 4-word memory, then step into halt
    sel = 1'b1;
    wq_b.delete();
    send_word(32'h0000_0013, 1);
    send_word(32'h1234_5678, 0);
    send_word(32'hDEAD_BEEF, 1);
    send_word(32'h0040_0093, 0);
    send(8'hFF, 3);
    chk("ovf_nwrites", 32'(wq_b.size()), 32'd4);
    if (wq_b.size() == 4) begin
      chk("ovf_last_addr", wq_b[3][63:32], 32'd12);
      chk("ovf_last_word", wq_b[3][31:0], 32'h0040_0093);
      chk("ovf_addr1", wq_b[1][63:32], 32'd4);
    end
    chk("ovf_err", 32'(err_b), 32'd1);
    chk("ovf_done", 32'(done_b), 32'd1);
    chk("ovf_debug", 32'(dbg_b), 32'd0);
    p0 = pipe_cnt_b;
    halt = 1'b1;
    send(8'h53, 1);
    halt = 1'b0;
    send(8'h43, 3);
    chk("step_to_done", 32'(pipe_cnt_b - p0), 32'd1);
    sel = 1'b0;

    // test 6: reset mid-word
    send(8'h11, 0);
    send(8'h22, 1);
    rst_a = 1'b0;
    cyc();
    rst_a = 1'b1;
    cyc();
    wq_a.delete();
    send_word(32'h1234_5678, 0);
    repeat (2) cyc();
    chk("rstmid_n", 32'(wq_a.size()), 32'd1);
    if (wq_a.size() > 0) begin
      chk("rstmid_addr", wq_a[0][63:32], 32'd0);
      chk("rstmid_word", wq_a[0][31:0], 32'h1234_5678);
    end

    // randomized loads vs word-list model
    for (int it = 0; it < 4; it++) begin
      rst_a = 1'b0;
      cyc();
      rst_a = 1'b1;
      cyc();
      wq_a.delete();
      exp_q.delete();
      n = $urandom_range(3, 12);
      for (int i = 0; i <= n; i++) begin
        w = $urandom;
        if (w == 32'hFFFF_FFFF) w = 32'h0;
        if (i == n) w = 32'hFFFF_FFFF;
        exp_q.push_back({32'(4 * i), w});
        for (int k = 0; k < 4; k++) begin
          halt = 1'($urandom_range(0, 1));
          send(w[31-8*k -: 8], $urandom_range(0, 2));
        end
      end
      // a command arriving in the final WRITE cycle is dropped
      if (wea_a) send(8'h43, 0);
      halt = 1'b0;
      p0 = pipe_cnt_a;
      repeat (3) cyc();
      chk("rnd_nwrites", 32'(wq_a.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
        act_e = (i < wq_a.size()) ? wq_a[i] : 64'hX;
        exp_e = exp_q[i];
        chk("rnd_addr", act_e[63:32], exp_e[63:32]);
        chk("rnd_word", act_e[31:0], exp_e[31:0]);
      end
      chk("rnd_done", 32'(done_a), 32'd1);
      chk("rnd_err", 32'(err_a), 32'd0);
      chk("rnd_idle", 32'(pipe_cnt_a - p0), 32'd0);
      p0 = pipe_cnt_a;
      send(8'h53, 3);
      chk("rnd_step", 32'(pipe_cnt_a - p0), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
